// File: rtl/sprite_mover.sv
// sprite_mover: erases a rectangular sprite at its previous position, then
// draws it at a new one, one clipped pixel per cycle for vga_adapter.
//
// Ports:
//   clock, reset        : system clock, synchronous active-high reset
//   req                 : start a move (sampled only while idle)
//   nextX, nextY        : new top-left corner of the sprite
//   colour              : sprite colour for the draw pass
//   erase_en            : erase the previous position before drawing
//   busy, done          : busy for the whole move, done pulses at its end
//   oX, oY, oColour     : pixel address and colour
//   oPlot               : pixel write enable (low for off-screen pixels)
module sprite_mover #(
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int COLOUR_W  = 9,
    parameter int SCREEN_W  = 160,
    parameter int SCREEN_H  = 120,
    parameter int SPR_W     = 10,
    parameter int SPR_H     = 10,
    parameter int BG_COLOUR = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req,
    input  logic [X_W-1:0]      nextX,
    input  logic [Y_W-1:0]      nextY,
    input  logic [COLOUR_W-1:0] colour,
    input  logic                erase_en,
    output logic                busy,
    output logic                done,
    output logic [X_W-1:0]      oX,
    output logic [Y_W-1:0]      oY,
    output logic [COLOUR_W-1:0] oColour,
    output logic                oPlot
);

    localparam int CX_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int CY_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    localparam logic [CX_W-1:0]     CX_LAST = CX_W'(SPR_W - 1);
    localparam logic [CY_W-1:0]     CY_LAST = CY_W'(SPR_H - 1);
    localparam logic [X_W:0]        SCR_W   = (X_W + 1)'(SCREEN_W);
    localparam logic [Y_W:0]        SCR_H   = (Y_W + 1)'(SCREEN_H);
    localparam logic [COLOUR_W-1:0] BG      = COLOUR_W'(BG_COLOUR);

    typedef enum logic [1:0] {
        IDLE,
        ERASE,
        DRAW,
        DONE
    } state_t;

    state_t state;

    logic [CX_W-1:0]     cx;
    logic [CY_W-1:0]     cy;
    logic [X_W-1:0]      lat_x;
    logic [Y_W-1:0]      lat_y;
    logic [COLOUR_W-1:0] lat_col;
    logic [X_W-1:0]      prev_x;
    logic [Y_W-1:0]      prev_y;
    logic                have_prev;

    logic                last_col;
    logic                last_pix;
    logic                start_erase;
    logic [CX_W-1:0]     step_cx;
    logic [CY_W-1:0]     step_cy;

    // Pixel that will be presented on the outputs after the next edge.
    logic [X_W-1:0]      pb_x;
    logic [Y_W-1:0]      pb_y;
    logic [CX_W-1:0]     pc_x;
    logic [CY_W-1:0]     pc_y;
    logic [COLOUR_W-1:0] p_col;
    logic [X_W:0]        sum_x;
    logic [Y_W:0]        sum_y;
    logic                pix_on;

    always_comb begin
        last_col    = (cx == CX_LAST);
        last_pix    = last_col && (cy == CY_LAST);
        step_cx     = last_col ? '0 : cx + CX_W'(1);
        step_cy     = last_col ? cy + CY_W'(1) : cy;
        start_erase = erase_en && have_prev;

        pb_x  = lat_x;
        pb_y  = lat_y;
        pc_x  = '0;
        pc_y  = '0;
        p_col = lat_col;

        unique case (state)
            IDLE: begin
                if (start_erase) begin
                    pb_x  = prev_x;
                    pb_y  = prev_y;
                    p_col = BG;
                end else begin
                    pb_x  = nextX;
                    pb_y  = nextY;
                    p_col = colour;
                end
            end
            ERASE: begin
                // On the last erase pixel the defaults select draw pixel 0.
                if (!last_pix) begin
                    pb_x  = prev_x;
                    pb_y  = prev_y;
                    pc_x  = step_cx;
                    pc_y  = step_cy;
                    p_col = BG;
                end
            end
            DRAW: begin
                pc_x = step_cx;
                pc_y = step_cy;
            end
            default: begin
            end
        endcase

        // One extra bit so pixels past the screen edge are seen, not wrapped.
        sum_x  = {1'b0, pb_x} + (X_W + 1)'(pc_x);
        sum_y  = {1'b0, pb_y} + (Y_W + 1)'(pc_y);
        pix_on = (sum_x < SCR_W) && (sum_y < SCR_H);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            oX        <= '0;
            oY        <= '0;
            oColour   <= '0;
            oPlot     <= 1'b0;
            cx        <= '0;
            cy        <= '0;
            lat_x     <= '0;
            lat_y     <= '0;
            lat_col   <= '0;
            prev_x    <= '0;
            prev_y    <= '0;
            have_prev <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done  <= 1'b0;
                    oPlot <= 1'b0;
                    if (req) begin
                        lat_x   <= nextX;
                        lat_y   <= nextY;
                        lat_col <= colour;
                        cx      <= '0;
                        cy      <= '0;
                        busy    <= 1'b1;
                        state   <= start_erase ? ERASE : DRAW;
                        oX      <= sum_x[X_W-1:0];
                        oY      <= sum_y[Y_W-1:0];
                        oColour <= p_col;
                        oPlot   <= pix_on;
                    end
                end
                ERASE: begin
                    if (last_pix) begin
                        cx    <= '0;
                        cy    <= '0;
                        state <= DRAW;
                    end else begin
                        cx <= step_cx;
                        cy <= step_cy;
                    end
                    oX      <= sum_x[X_W-1:0];
                    oY      <= sum_y[Y_W-1:0];
                    oColour <= p_col;
                    oPlot   <= pix_on;
                end
                DRAW: begin
                    if (last_pix) begin
                        state <= DONE;
                        done  <= 1'b1;
                        oPlot <= 1'b0;
                    end else begin
                        cx      <= step_cx;
                        cy      <= step_cy;
                        oX      <= sum_x[X_W-1:0];
                        oY      <= sum_y[Y_W-1:0];
                        oColour <= p_col;
                        oPlot   <= pix_on;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    oPlot     <= 1'b0;
                    prev_x    <= lat_x;
                    prev_y    <= lat_y;
                    have_prev <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_mover.sv
// Directed testbench for sprite_mover with default parameters
// (160x120 screen, 10x10 sprite, background colour 0).
module tb_sprite_mover;

    logic       clock;
    logic       reset;
    logic       req;
    logic [7:0] nextX;
    logic [6:0] nextY;
    logic [8:0] colour;
    logic       erase_en;
    logic       busy;
    logic       done;
    logic [7:0] oX;
    logic [6:0] oY;
    logic [8:0] oColour;
    logic       oPlot;

    int n_tests = 0;
    int n_fail  = 0;
    int last_plots;

    sprite_mover dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .nextX    (nextX),
        .nextY    (nextY),
        .colour   (colour),
        .erase_en (erase_en),
        .busy     (busy),
        .done     (done),
        .oX       (oX),
        .oY       (oY),
        .oColour  (oColour),
        .oPlot    (oPlot)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    // Issue one move and check every output cycle.
    // exp_er: erase pass expected (from px,py); poke: pixel index at which
    // a stray req with junk inputs is raised; abort: pixel index at which
    // reset is asserted instead of finishing the move.
    task automatic do_move(input int x, input int y, input int col,
                           input bit er, input bit exp_er,
                           input int px, input int py,
                           input int poke, input int abort);
        int n, k, bx, by, ex, ey, ecol, eplot, plots;
        bit in_erase;
        @(negedge clock);
        nextX    = 8'(x);
        nextY    = 7'(y);
        colour   = 9'(col);
        erase_en = er;
        req      = 1'b1;
        @(negedge clock);
        n     = exp_er ? 200 : 100;
        plots = 0;
        for (int i = 0; i < n; i++) begin
            req = 1'b0;
            if (i == abort) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                chk("rst_mid_plot", oPlot, 0);
                chk("rst_mid_busy", busy, 0);
                chk("rst_mid_done", done, 0);
                chk("rst_mid_x", oX, 0);
                chk("rst_mid_col", oColour, 0);
                return;
            end
            in_erase = exp_er && (i < 100);
            k     = (exp_er && !in_erase) ? i - 100 : i;
            bx    = in_erase ? px : x;
            by    = in_erase ? py : y;
            ex    = bx + k % 10;
            ey    = by + k / 10;
            ecol  = in_erase ? 0 : col;
            eplot = (ex < 160 && ey < 120) ? 1 : 0;
            chk("busy", busy, 1);
            chk("done_early", done, 0);
            chk("plot", oPlot, eplot);
            chk("x", oX, ex % 256);
            chk("y", oY, ey % 128);
            chk("colour", oColour, ecol);
            plots += oPlot;
            if (i == poke) begin
                nextX    = 8'd1;
                nextY    = 7'd2;
                colour   = 9'h155;
                erase_en = 1'b1;
                req      = 1'b1;
            end
            @(negedge clock);
        end
        chk("done", done, 1);
        chk("done_busy", busy, 1);
        chk("done_plot", oPlot, 0);
        @(negedge clock);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_plot", oPlot, 0);
        last_plots = plots;
    endtask

    initial begin
        reset    = 1'b1;
        req      = 1'b0;
        nextX    = '0;
        nextY    = '0;
        colour   = '0;
        erase_en = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_plot", oPlot, 0);
        chk("rst_x", oX, 0);
        chk("rst_y", oY, 0);
        chk("rst_col", oColour, 0);
        reset = 1'b0;

        // First move: erase requested but nothing drawn yet.
        do_move(50, 40, 'h1C0, 1, 0, 0, 0, -1, -1);
        chk("first_plots", last_plots, 100);
        // Erase old, draw new.
        do_move(100, 80, 'h038, 1, 1, 50, 40, -1, -1);
        chk("move2_plots", last_plots, 200);
        // Clipped at bottom-right corner.
        do_move(155, 115, 'h007, 0, 0, 0, 0, -1, -1);
        chk("clip_plots", last_plots, 25);
        // Erase of a clipped sprite, stray req at pixel 10.
        do_move(20, 30, 'h1FF, 1, 1, 155, 115, 9, -1);
        chk("poke_plots", last_plots, 125);
        // Reset at pixel 37 of the draw.
        do_move(60, 60, 'h0AA, 0, 0, 0, 0, -1, 36);
        // After reset no erase is performed.
        do_move(70, 10, 'h111, 1, 0, 0, 0, -1, -1);
        // Erase disabled after a prior move: draw only.
        do_move(5, 5, 'h0F0, 0, 0, 0, 0, -1, -1);
        chk("noerase_plots", last_plots, 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
